// File: rtl/mario_motion.sv
// mario_motion: per-frame Mario position, jump/gravity FSM and sprite hit test.
// Define MARIO_WRAP_EN for horizontal wrap-around instead of edge clamping.
module mario_motion #(
    parameter int unsigned X_START  = 320,
    parameter int unsigned Y_GROUND = 400,
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned SPR_W    = 16,
    parameter int unsigned SPR_H    = 16,
    parameter int unsigned X_STEP   = 2,
    parameter int unsigned JUMP_VEL = 12,
    parameter int unsigned GRAVITY  = 1,
    parameter int unsigned MAX_FALL = 8
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [9:0] Mario_X,
    output logic [9:0] Mario_Y,
    output logic       Is_Mario,
    output logic       Airborne
);

    typedef enum logic [1:0] {
        GROUND,
        RISING,
        FALLING
    } state_t;

    localparam logic [10:0] SCR   = 11'(SCREEN_W);
    localparam logic [10:0] X_MAX = 11'(SCREEN_W - SPR_W);
    localparam logic [10:0] STEP  = 11'(X_STEP);
    localparam logic [10:0] SW    = 11'(SPR_W);
    localparam logic [10:0] SH    = 11'(SPR_H);
    localparam logic [10:0] YG    = 11'(Y_GROUND);
    localparam logic [9:0]  X0    = 10'(X_START);
    localparam logic [7:0]  JV    = 8'(JUMP_VEL);
    localparam logic [7:0]  GR    = 8'(GRAVITY);
    localparam logic [8:0]  MF    = 9'(MAX_FALL);

    state_t      state_q, state_d;
    logic [7:0]  vel_q, vel_d;
    logic [9:0]  x_d, y_d;
    logic        fs1, fs2, fdly, tick;
    logic [10:0] x_w, y_w, dx, dy;
    logic [10:0] x_sum, x_end, y_end, fall_y;
    logic [8:0]  fall_sum;
    logic [7:0]  fall_vel, rise_vel;
    logic        go_left, go_right, go_jump;
    logic        in_x, in_y;

    assign x_w      = {1'b0, Mario_X};
    assign y_w      = {1'b0, Mario_Y};
    assign dx       = {1'b0, DrawX};
    assign dy       = {1'b0, DrawY};
    assign go_left  = (keycode == 8'h04);
    assign go_right = (keycode == 8'h07);
    assign go_jump  = (keycode == 8'h1A);

    // frame_clk is asynchronous: synchronise, then edge-detect to one pulse
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fs1  <= 1'b0;
            fs2  <= 1'b0;
            fdly <= 1'b0;
        end else begin
            fs1  <= frame_clk;
            fs2  <= fs1;
            fdly <= fs2;
        end
    end

    assign tick = fs2 & ~fdly;

    always_comb begin
        x_sum = x_w + STEP;
        x_d   = Mario_X;
        unique case (1'b1)
            go_left: begin
`ifdef MARIO_WRAP_EN
                x_d = (x_w < STEP) ? 10'(SCR + x_w - STEP)
                                   : 10'(x_w - STEP);
`else
                x_d = (x_w < STEP) ? 10'd0 : 10'(x_w - STEP);
`endif
            end
            go_right: begin
`ifdef MARIO_WRAP_EN
                x_d = (x_sum >= SCR) ? 10'(x_sum - SCR) : x_sum[9:0];
`else
                x_d = (x_sum > X_MAX) ? X_MAX[9:0] : x_sum[9:0];
`endif
            end
            default: x_d = Mario_X;
        endcase
    end

    // vel is a magnitude; its sign comes from RISING vs FALLING
    always_comb begin
        state_d  = state_q;
        vel_d    = vel_q;
        y_d      = Mario_Y;
        rise_vel = vel_q - GR;
        fall_sum = {1'b0, vel_q} + {1'b0, GR};
        fall_vel = (fall_sum > MF) ? MF[7:0] : fall_sum[7:0];
        fall_y   = y_w + {3'b000, fall_vel};
        unique case (state_q)
            GROUND: begin
                if (go_jump) begin
                    vel_d   = JV;
                    state_d = RISING;
                end else begin
                    y_d = YG[9:0];
                end
            end
            RISING: begin
                if (y_w < {3'b000, vel_q}) begin
                    y_d     = 10'd0;
                    vel_d   = 8'd0;
                    state_d = FALLING;
                end else begin
                    y_d   = 10'(y_w - {3'b000, vel_q});
                    vel_d = rise_vel;
                    if (rise_vel == 8'd0) state_d = FALLING;
                end
            end
            FALLING: begin
                if (fall_y >= YG) begin
                    y_d     = YG[9:0];
                    vel_d   = 8'd0;
                    state_d = GROUND;
                end else begin
                    y_d   = fall_y[9:0];
                    vel_d = fall_vel;
                end
            end
            default: begin
                y_d     = YG[9:0];
                vel_d   = 8'd0;
                state_d = GROUND;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= GROUND;
            vel_q    <= 8'd0;
            Mario_X  <= X0;
            Mario_Y  <= YG[9:0];
            Airborne <= 1'b0;
        end else if (tick) begin
            state_q  <= state_d;
            vel_q    <= vel_d;
            Mario_X  <= x_d;
            Mario_Y  <= y_d;
            Airborne <= (state_d != GROUND);
        end
    end

    always_comb begin
        x_end = x_w + SW;
        y_end = y_w + SH;
        in_x  = (dx >= x_w) && (dx < x_end);
        in_y  = (dy >= y_w) && (dy < y_end);
`ifdef MARIO_WRAP_EN
        if ((x_end > SCR) && (dx < x_end - SCR)) in_x = 1'b1;
`endif
        Is_Mario = in_x & in_y;
    end

endmodule

// File: tb/tb_mario_motion.sv
// Scoreboard bench for mario_motion: stimulus queues expectations,
// a monitor pops and compares them on the falling clock edge.
module tb_mario_motion;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic [9:0] DrawX = 10'd0;
    logic [9:0] DrawY = 10'd0;
    logic [9:0] Mario_X, Mario_Y;
    logic       Is_Mario, Airborne;

    bit clk_en = 1'b1;
    int errors = 0;
    int checks = 0;

    typedef struct {
        string      name;
        bit         pix;
        logic [9:0] x;
        logic [9:0] y;
        logic       v;
    } exp_t;

    exp_t sb[$];
    event sample_ev;

    mario_motion dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .frame_clk(frame_clk),
        .keycode  (keycode),
        .DrawX    (DrawX),
        .DrawY    (DrawY),
        .Mario_X  (Mario_X),
        .Mario_Y  (Mario_Y),
        .Is_Mario (Is_Mario),
        .Airborne (Airborne)
    );

    always #5 if (clk_en) Clk = ~Clk;

    initial begin
        exp_t e;
        forever begin
            @(negedge Clk or sample_ev);
            while (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (e.pix) begin
                    if (Is_Mario !== e.v) begin
                        errors++;
                        $display("FAIL %s: Is_Mario=%0b want %0b at (%0d,%0d)",
                                 e.name, Is_Mario, e.v, DrawX, DrawY);
                    end
                end else if (Mario_X !== e.x || Mario_Y !== e.y ||
                             Airborne !== e.v) begin
                    errors++;
                    $display("FAIL %s: X=%0d Y=%0d air=%0b want X=%0d Y=%0d air=%0b",
                             e.name, Mario_X, Mario_Y, Airborne, e.x, e.y, e.v);
                end
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            #5;
            n++;
        end
        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d checks pending, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic pos(input string nm, input int x, input int y, input bit a);
        exp_t e;
        e.name = nm; e.pix = 1'b0;
        e.x = 10'(x); e.y = 10'(y); e.v = a;
        sb.push_back(e);
        drain();
    endtask

    task automatic pix(input string nm, input int px, input int py, input bit v);
        exp_t e;
        DrawX = 10'(px);
        DrawY = 10'(py);
        e.name = nm; e.pix = 1'b1;
        e.x = 10'(px); e.y = 10'(py); e.v = v;
        sb.push_back(e);
        drain();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            frame_clk = 1'b1;
            repeat (4) @(negedge Clk);
            frame_clk = 1'b0;
            repeat (4) @(negedge Clk);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        keycode = 8'h00;
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset();
        pos("reset", 320, 400, 0);
        pix("pix_tl", 320, 400, 1);
        pix("pix_br", 335, 415, 1);
        pix("pix_right_out", 336, 400, 0);
        pix("pix_below_out", 320, 416, 0);

        keycode = 8'h07;
        ticks(5);
        pos("right5", 330, 400, 0);
        keycode = 8'h1B;
        ticks(1);
        pos("other_key_hold", 330, 400, 0);
        keycode = 8'h07;
        ticks(146);
        pos("right_to_622", 622, 400, 0);
`ifdef MARIO_WRAP_EN
        ticks(8);
        pos("right_to_638", 638, 400, 0);
        ticks(1);
        pos("wrap_right", 0, 400, 0);
        keycode = 8'h04;
        ticks(1);
        pos("wrap_left", 638, 400, 0);
        ticks(4);
        pos("left_to_630", 630, 400, 0);
        pix("wrap_pix_in", 2, 405, 1);
        pix("wrap_pix_last", 5, 405, 1);
        pix("wrap_pix_out", 6, 405, 0);
        pix("wrap_pix_main", 639, 405, 1);
`else
        ticks(1);
        pos("clamp_r1", 624, 400, 0);
        ticks(1);
        pos("clamp_r2", 624, 400, 0);
        pix("edge_pix_in", 639, 415, 1);
        pix("edge_pix_out", 623, 400, 0);
        do_reset();
        keycode = 8'h04;
        ticks(160);
        pos("left_to_0", 0, 400, 0);
        ticks(1);
        pos("clamp_l", 0, 400, 0);
`endif

        do_reset();
        keycode = 8'h1A;
        ticks(1);
        pos("jump_t1", 320, 400, 1);
        keycode = 8'h00;
        ticks(1);
        pos("jump_t2", 320, 388, 1);
        ticks(11);
        pos("apex_t13", 320, 322, 1);
        pix("pix_apex", 327, 330, 1);
        ticks(13);
        pos("fall13", 320, 398, 1);
        ticks(1);
        pos("landed", 320, 400, 0);
        ticks(2);
        pos("ground_hold", 320, 400, 0);

        keycode = 8'h07;
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (1000) @(negedge Clk);
        pos("long_high", 322, 400, 0);
        frame_clk = 1'b0;
        repeat (6) @(negedge Clk);
        pos("long_once", 322, 400, 0);

        do_reset();
        keycode = 8'h1A;
        ticks(6);
        pos("midjump_350", 320, 350, 1);
        clk_en = 1'b0;
        #7;
        Reset_n = 1'b0;
        #1;
        sb.push_back('{name: "async_reset", pix: 1'b0,
                       x: 10'd320, y: 10'd400, v: 1'b0});
        -> sample_ev;
        drain();
        #3;
        Reset_n = 1'b1;
        keycode = 8'h00;
        clk_en = 1'b1;
        repeat (3) @(negedge Clk);
        pos("after_async", 320, 400, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mario_motion.md
Name: mario_motion

Overview:
- Computes Mario's on-screen position once per video frame from the current keyboard keycode: walks left and right, jumps and falls under gravity.
- Produces the per-pixel Is_Mario flag that color_mapper consumes, so it sits directly upstream of color_mapper.
- Runs in the 50 MHz Clk domain; frame_clk is the VGA vertical-sync-rate strobe.

Parameters:
- X_START, 320: X position after reset.
- Y_GROUND, 400: Y of Mario's top edge when standing on the ground.
- SCREEN_W, 640: visible width in pixels.
- SPR_W, 16: sprite width in pixels.
- SPR_H, 16: sprite height in pixels.
- X_STEP, 2: horizontal pixels moved per frame while a direction key is held.
- JUMP_VEL, 12: initial upward velocity, in pixels per frame.
- GRAVITY, 1: velocity change per frame.
- MAX_FALL, 8: terminal downward velocity, in pixels per frame.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_clk  in  1  frame strobe, asynchronous to Clk, level signal.
- keycode  in  8  USB HID keycode of the held key; 0 means no key.
- DrawX  in  10  current pixel X.
- DrawY  in  10  current pixel Y.
- Mario_X  out  10  sprite top-left X.
- Mario_Y  out  10  sprite top-left Y.
- Is_Mario  out  1  high when (DrawX, DrawY) lies inside the sprite box.
- Airborne  out  1  high when the state is not GROUND.

Behaviour:
- Reset (async, Reset_n=0):
  - Mario_X=X_START, Mario_Y=Y_GROUND, state=GROUND, vel=0, Airborne=0.
  - Sync and edge flops cleared.
  - Reset mid-jump aborts the jump immediately.
- Frame tick:
  - frame_clk passes through a 2-flop synchronizer, then a delay flop.
  - frame_tick = sync & ~delayed, a single Clk-cycle pulse per rising edge of frame_clk.
  - All position, velocity and state registers update only on Clk edges where frame_tick=1; otherwise they hold.
- Horizontal motion (per tick), keycode 0x04 (A) = left, 0x07 (D) = right:
  - Left: if Mario_X < X_STEP then 0, else Mario_X-X_STEP.
  - Right: if Mario_X+X_STEP > SCREEN_W-SPR_W then SCREEN_W-SPR_W, else Mario_X+X_STEP.
  - Any other keycode: X holds.
  - Arithmetic is 11-bit unsigned, so there is no overflow.
- Vertical FSM. vel is an 8-bit magnitude; direction is implied by the state.
  - GROUND: keycode 0x1A (W) on a tick → vel=JUMP_VEL, state RISING, Y unchanged that tick. Otherwise Y holds at Y_GROUND.
  - RISING (per tick): if Mario_Y < vel then Y=0, vel=0, state FALLING (ceiling hit). Else Y=Y-vel and vel=vel-GRAVITY; if the new vel is 0, state FALLING.
  - FALLING (per tick): vel=min(vel+GRAVITY, MAX_FALL), then Y=Y+new vel. If the result is ≥ Y_GROUND, Y=Y_GROUND, vel=0, state GROUND.
  - Holding W while RISING or FALLING has no effect.
  - Horizontal and vertical updates apply on the same tick, independently.
- Airborne = (state != GROUND), registered.
- Is_Mario is combinational, zero latency relative to DrawX/DrawY:
  - Is_Mario = (DrawX ≥ Mario_X) & (DrawX < Mario_X+SPR_W) & (DrawY ≥ Mario_Y) & (DrawY < Mario_Y+SPR_H).
  - Compares use 11-bit sums.
- Mario_X and Mario_Y change only in the Clk cycle after a tick, so they are stable across a scanline.

Optional Feature:
- Macro MARIO_WRAP_EN.
- Defined: horizontal motion wraps modulo SCREEN_W.
  - Left at X < X_STEP gives X = SCREEN_W + X - X_STEP.
  - Right gives X = (X+X_STEP) mod SCREEN_W.
  - Is_Mario additionally matches the wrapped portion: when Mario_X+SPR_W > SCREEN_W, it also matches DrawX < Mario_X+SPR_W-SCREEN_W.
- Undefined: the clamp rules above apply and there is no wrap logic.

Test Plan:
- Reset release, no ticks → Mario_X=320, Mario_Y=400, Airborne=0. Is_Mario=1 at (320,400) and (335,415); 0 at (336,400) and (320,416).
- keycode=0x07 held for 5 ticks → Mario_X=330.
  - Start at X=622 (clamp build), 2 ticks → X stays at 624.
  - X=1, keycode 0x04 → X=0.
- keycode=0x1A for one tick, then 0 → Y=400 and Airborne=1 after tick 1.
  - Y=388 after tick 2; Y=322 with state FALLING after tick 13.
  - Y=398 after 13 falling ticks; Y=400, GROUND, Airborne=0 after the 14th.
- frame_clk held high for 1000 Clk cycles → exactly one tick; positions change once only.
- Reset_n pulsed low mid-RISING (Y=350), asynchronous to Clk → outputs return to reset values without waiting for a Clk edge.
- MARIO_WRAP_EN defined, X=638, keycode 0x07, one tick → X=0.
  - With X=630: Is_Mario=1 at DrawX=2, Y inside the sprite rows.
